// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection, branch flush and a bubble counter.
// Latency: one cycle from ID inputs to ex_* outputs; stall_o is combinational in the same cycle.
// Backpressure: stall_o holds PC and IF/ID for one cycle while a bubble is inserted; flush_i overrides it.
//
// Ports:
//   clk_i, rst_i (synchronous, active-low)
//   id_*  : instruction, PC+4, register read data and decoder controls from ID
//   flush_i : taken branch resolved downstream, kills the ID instruction
//   stall_o : hold PC and IF/ID this cycle
//   ex_*  : registered bundle for EX
//   bubble_cnt_o : saturating count of load-use bubbles
module id_ex_stage #(
  parameter int DW    = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             id_valid_i,
  input  logic [31:0]      id_instr_i,
  input  logic [DW-1:0]    id_pc_plus4_i,
  input  logic [DW-1:0]    id_rs_data_i,
  input  logic [DW-1:0]    id_rt_data_i,
  input  logic             id_RegWrite_i,
  input  logic             id_ALUSrc_i,
  input  logic             id_RegDst_i,
  input  logic             id_Branch_i,
  input  logic             id_MemRead_i,
  input  logic             id_MemWrite_i,
  input  logic             id_MemtoReg_i,
  input  logic [2:0]       id_ALU_op_i,
  input  logic             flush_i,
  output logic             stall_o,
  output logic             ex_valid_o,
  output logic [5:0]       ex_op_o,
  output logic [DW-1:0]    ex_pc_plus4_o,
  output logic [DW-1:0]    ex_rs_data_o,
  output logic [DW-1:0]    ex_rt_data_o,
  output logic [DW-1:0]    ex_imm_o,
  output logic [4:0]       ex_rs_o,
  output logic [4:0]       ex_rt_o,
  output logic [4:0]       ex_rd_o,
  output logic             ex_RegWrite_o,
  output logic             ex_ALUSrc_o,
  output logic             ex_RegDst_o,
  output logic             ex_Branch_o,
  output logic             ex_MemRead_o,
  output logic             ex_MemWrite_o,
  output logic             ex_MemtoReg_o,
  output logic [2:0]       ex_ALU_op_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  typedef struct packed {
    logic          valid;
    logic [5:0]    op;
    logic [DW-1:0] pc_plus4;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
    logic [4:0]    rs;
    logic [4:0]    rt;
    logic [4:0]    rd;
    logic          reg_write;
    logic          alu_src;
    logic          reg_dst;
    logic          branch;
    logic          mem_read;
    logic          mem_write;
    logic          mem_to_reg;
    logic [2:0]    alu_op;
  } ex_bundle_t;

  ex_bundle_t       ex_q;
  ex_bundle_t       id_d;
  logic [CNT_W-1:0] bubble_cnt;

  logic [5:0] id_op;
  logic [4:0] id_rs;
  logic [4:0] id_rt;
  logic       uses_rt;
  logic       load_use;
  logic       bubble;

  assign id_op = id_instr_i[31:26];
  assign id_rs = id_instr_i[25:21];
  assign id_rt = id_instr_i[20:16];

  // Opcodes that read rt as a source: R-type, beq, bne, bge, bgt, sw.
  always_comb begin
    uses_rt = 1'b0;
    case (id_op)
      6'b000000, 6'b000100, 6'b000101,
      6'b000001, 6'b000111, 6'b101011: uses_rt = 1'b1;
      default:                         uses_rt = 1'b0;
    endcase
  end

  // A load in EX whose destination feeds the ID instruction; $0 never creates a dependency.
  assign load_use = id_valid_i && ex_q.valid && ex_q.mem_read && (ex_q.rt != 5'd0) &&
                    ((ex_q.rt == id_rs) || (uses_rt && (ex_q.rt == id_rt)));

  // A flush discards the dependent instruction anyway, so holding it would be wasted.
  assign stall_o = load_use && !flush_i;
  assign bubble  = flush_i || load_use || !id_valid_i;

  always_comb begin
    id_d            = '0;
    id_d.valid      = 1'b1;
    id_d.op         = id_op;
    id_d.pc_plus4   = id_pc_plus4_i;
    id_d.rs_data    = id_rs_data_i;
    id_d.rt_data    = id_rt_data_i;
    id_d.imm        = {{(DW-16){id_instr_i[15]}}, id_instr_i[15:0]};
    id_d.rs         = id_rs;
    id_d.rt         = id_rt;
    id_d.rd         = id_instr_i[15:11];
    id_d.reg_write  = id_RegWrite_i;
    id_d.alu_src    = id_ALUSrc_i;
    id_d.reg_dst    = id_RegDst_i;
    id_d.branch     = id_Branch_i;
    id_d.mem_read   = id_MemRead_i;
    id_d.mem_write  = id_MemWrite_i;
    id_d.mem_to_reg = id_MemtoReg_i;
    id_d.alu_op     = id_ALU_op_i;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ex_q       <= '0;
      bubble_cnt <= '0;
    end else begin
      ex_q <= bubble ? '0 : id_d;
      // Only hazard bubbles are counted; a coincident flush takes precedence.
      if (stall_o && (bubble_cnt != {CNT_W{1'b1}})) begin
        bubble_cnt <= bubble_cnt + 1'b1;
      end
    end
  end

  assign ex_valid_o    = ex_q.valid;
  assign ex_op_o       = ex_q.op;
  assign ex_pc_plus4_o = ex_q.pc_plus4;
  assign ex_rs_data_o  = ex_q.rs_data;
  assign ex_rt_data_o  = ex_q.rt_data;
  assign ex_imm_o      = ex_q.imm;
  assign ex_rs_o       = ex_q.rs;
  assign ex_rt_o       = ex_q.rt;
  assign ex_rd_o       = ex_q.rd;
  assign ex_RegWrite_o = ex_q.reg_write;
  assign ex_ALUSrc_o   = ex_q.alu_src;
  assign ex_RegDst_o   = ex_q.reg_dst;
  assign ex_Branch_o   = ex_q.branch;
  assign ex_MemRead_o  = ex_q.mem_read;
  assign ex_MemWrite_o = ex_q.mem_write;
  assign ex_MemtoReg_o = ex_q.mem_to_reg;
  assign ex_ALU_op_o   = ex_q.alu_op;
  assign bubble_cnt_o  = bubble_cnt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Testbench for id_ex_stage: directed scenarios plus randomized traffic against an
// instruction-level reference model of the EX register contents and bubble counters.
// Two instances share stimulus: default widths, and a 2-bit bubble counter for saturation.
module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        id_valid_i;
  logic [31:0] id_instr_i;
  logic [31:0] id_pc_plus4_i;
  logic [31:0] id_rs_data_i;
  logic [31:0] id_rt_data_i;
  logic [6:0]  ctrl;      // RegWrite, ALUSrc, RegDst, Branch, MemRead, MemWrite, MemtoReg
  logic [2:0]  id_ALU_op_i;
  logic        flush_i;

  logic        stall_o, ex_valid_o;
  logic [5:0]  ex_op_o;
  logic [31:0] ex_pc_plus4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o;
  logic [4:0]  ex_rs_o, ex_rt_o, ex_rd_o;
  logic        ex_RegWrite_o, ex_ALUSrc_o, ex_RegDst_o, ex_Branch_o;
  logic        ex_MemRead_o, ex_MemWrite_o, ex_MemtoReg_o;
  logic [2:0]  ex_ALU_op_o;
  logic [15:0] bubble_cnt_o;

  logic        stall2, valid2;
  logic [5:0]  op2;
  logic [31:0] pc2, rsd2, rtd2, imm2;
  logic [4:0]  rs2, rt2, rd2;
  logic        rw2, as2, rdst2, br2, mr2, mw2, m2r2;
  logic [2:0]  alu2;
  logic [1:0]  cnt2;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk_i = ~clk_i;

  id_ex_stage #(.DW(32), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_instr_i(id_instr_i),
    .id_pc_plus4_i(id_pc_plus4_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
    .id_RegWrite_i(ctrl[6]), .id_ALUSrc_i(ctrl[5]), .id_RegDst_i(ctrl[4]), .id_Branch_i(ctrl[3]),
    .id_MemRead_i(ctrl[2]), .id_MemWrite_i(ctrl[1]), .id_MemtoReg_i(ctrl[0]),
    .id_ALU_op_i(id_ALU_op_i), .flush_i(flush_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_op_o(ex_op_o), .ex_pc_plus4_o(ex_pc_plus4_o),
    .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o), .ex_imm_o(ex_imm_o),
    .ex_rs_o(ex_rs_o), .ex_rt_o(ex_rt_o), .ex_rd_o(ex_rd_o),
    .ex_RegWrite_o(ex_RegWrite_o), .ex_ALUSrc_o(ex_ALUSrc_o), .ex_RegDst_o(ex_RegDst_o),
    .ex_Branch_o(ex_Branch_o), .ex_MemRead_o(ex_MemRead_o), .ex_MemWrite_o(ex_MemWrite_o),
    .ex_MemtoReg_o(ex_MemtoReg_o), .ex_ALU_op_o(ex_ALU_op_o), .bubble_cnt_o(bubble_cnt_o)
  );

  id_ex_stage #(.DW(32), .CNT_W(2)) dut2 (
    .clk_i(clk_i), .rst_i(rst_i), .id_valid_i(id_valid_i), .id_instr_i(id_instr_i),
    .id_pc_plus4_i(id_pc_plus4_i), .id_rs_data_i(id_rs_data_i), .id_rt_data_i(id_rt_data_i),
    .id_RegWrite_i(ctrl[6]), .id_ALUSrc_i(ctrl[5]), .id_RegDst_i(ctrl[4]), .id_Branch_i(ctrl[3]),
    .id_MemRead_i(ctrl[2]), .id_MemWrite_i(ctrl[1]), .id_MemtoReg_i(ctrl[0]),
    .id_ALU_op_i(id_ALU_op_i), .flush_i(flush_i), .stall_o(stall2),
    .ex_valid_o(valid2), .ex_op_o(op2), .ex_pc_plus4_o(pc2),
    .ex_rs_data_o(rsd2), .ex_rt_data_o(rtd2), .ex_imm_o(imm2),
    .ex_rs_o(rs2), .ex_rt_o(rt2), .ex_rd_o(rd2),
    .ex_RegWrite_o(rw2), .ex_ALUSrc_o(as2), .ex_RegDst_o(rdst2),
    .ex_Branch_o(br2), .ex_MemRead_o(mr2), .ex_MemWrite_o(mw2),
    .ex_MemtoReg_o(m2r2), .ex_ALU_op_o(alu2), .bubble_cnt_o(cnt2)
  );

  logic [159:0] obs, obs2;
  assign obs  = {ex_valid_o, ex_op_o, ex_pc_plus4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o,
                 ex_rs_o, ex_rt_o, ex_rd_o, ex_RegWrite_o, ex_ALUSrc_o, ex_RegDst_o,
                 ex_Branch_o, ex_MemRead_o, ex_MemWrite_o, ex_MemtoReg_o, ex_ALU_op_o};
  assign obs2 = {valid2, op2, pc2, rsd2, rtd2, imm2, rs2, rt2, rd2,
                 rw2, as2, rdst2, br2, mr2, mw2, m2r2, alu2};

  // Reference model: the instruction currently sitting in EX, as a record.
  logic         m_valid;
  logic         m_memread;
  logic [4:0]   m_rt;
  logic [159:0] m_vec;
  int           m_cnt;
  int           m_cnt2;

  function automatic logic model_hazard();
    logic [5:0] op;
    logic       reads_rt;
    op = id_instr_i[31:26];
    reads_rt = op inside {6'h00, 6'h04, 6'h05, 6'h01, 6'h07, 6'h2B};
    return id_valid_i && m_valid && m_memread && (m_rt != 5'd0) &&
           ((m_rt == id_instr_i[25:21]) || (reads_rt && (m_rt == id_instr_i[20:16])));
  endfunction

  function automatic logic model_stall();
    return model_hazard() && !flush_i;
  endfunction

  task automatic model_clear();
    m_valid = 1'b0; m_memread = 1'b0; m_rt = 5'd0; m_vec = '0;
  endtask

  task automatic model_edge();
    logic hz;
    if (!rst_i) begin
      model_clear(); m_cnt = 0; m_cnt2 = 0;
    end else begin
      hz = model_hazard();
      if (flush_i) model_clear();
      else if (hz) begin
        model_clear();
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end else if (!id_valid_i) model_clear();
      else begin
        m_valid = 1'b1; m_memread = ctrl[2]; m_rt = id_instr_i[20:16];
        m_vec = {1'b1, id_instr_i[31:26], id_pc_plus4_i, id_rs_data_i, id_rt_data_i,
                 32'($signed(id_instr_i[15:0])), id_instr_i[25:21], id_instr_i[20:16],
                 id_instr_i[15:11], ctrl, id_ALU_op_i};
      end
    end
  endtask

  // Advance one clock: model follows the same edge, outputs settle 1 time unit later.
  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [6:0] c, input logic [2:0] alu);
    id_valid_i    = 1'b1;
    id_instr_i    = instr;
    ctrl          = c;
    id_ALU_op_i   = alu;
    id_pc_plus4_i = $urandom;
    id_rs_data_i  = $urandom;
    id_rt_data_i  = $urandom;
    flush_i       = 1'b0;
  endtask

  localparam logic [6:0] C_ALUI = 7'b1100000;
  localparam logic [6:0] C_LW   = 7'b1100101;
  localparam logic [6:0] C_RT   = 7'b1010000;
  localparam logic [31:0] LW8   = 32'h8D280000;  // lw  $8, 0($9)
  localparam logic [31:0] ADD8  = 32'h01095020;  // add $10,$8,$9

  task automatic test_reset();
    rst_i = 1'b0;
    drive($urandom, 7'($urandom), 3'($urandom));
    flush_i = 1'($urandom);
    tick(); tick();
    n_cmp++; if (obs !== 160'd0) begin n_fail++; $display("FAIL reset_ex obs=%h req=0", obs); end
    n_cmp++; if (bubble_cnt_o !== 16'd0) begin n_fail++; $display("FAIL reset_cnt obs=%0d req=0", bubble_cnt_o); end
    rst_i = 1'b1;
    drive(32'h00000000, 7'd0, 3'd0);
    id_valid_i = 1'b0;
    @(negedge clk_i);
    n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL reset_stall obs=%b req=0", stall_o); end
  endtask

  task automatic test_load();
    drive(32'h21280005, C_ALUI, 3'b000);
    tick();
    n_cmp++; if (ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL load_valid obs=%b req=1", ex_valid_o); end
    n_cmp++; if ({ex_rs_o, ex_rt_o} !== {5'd9, 5'd8}) begin n_fail++; $display("FAIL load_regs rs=%0d rt=%0d req 9/8", ex_rs_o, ex_rt_o); end
    n_cmp++; if (ex_imm_o !== 32'h00000005) begin n_fail++; $display("FAIL load_imm obs=%h req=00000005", ex_imm_o); end
    n_cmp++; if ({ex_RegWrite_o, ex_ALUSrc_o} !== 2'b11) begin n_fail++; $display("FAIL load_ctrl obs=%b%b req=11", ex_RegWrite_o, ex_ALUSrc_o); end
    n_cmp++; if (obs !== m_vec) begin n_fail++; $display("FAIL load_bundle obs=%h req=%h", obs, m_vec); end
    drive(32'h21288000, C_ALUI, 3'b000);
    tick();
    n_cmp++; if (ex_imm_o !== 32'hFFFF8000) begin n_fail++; $display("FAIL load_sext obs=%h req=FFFF8000", ex_imm_o); end
  endtask

  task automatic test_load_use();
    int cnt0;
    drive(LW8, C_LW, 3'b000);
    tick();
    cnt0 = m_cnt;
    drive(ADD8, C_RT, 3'b010);
    @(negedge clk_i);
    n_cmp++; if (stall_o !== 1'b1) begin n_fail++; $display("FAIL lu_stall obs=%b req=1", stall_o); end
    tick();
    n_cmp++; if (obs !== 160'd0) begin n_fail++; $display("FAIL lu_bubble obs=%h req=0", obs); end
    n_cmp++; if (bubble_cnt_o !== 16'(cnt0 + 1)) begin n_fail++; $display("FAIL lu_cnt obs=%0d req=%0d", bubble_cnt_o, cnt0 + 1); end
    @(negedge clk_i);
    n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL lu_release obs=%b req=0", stall_o); end
    tick();
    n_cmp++; if ({ex_valid_o, ex_rs_o} !== {1'b1, 5'd8}) begin n_fail++; $display("FAIL lu_reload valid=%b rs=%0d req 1/8", ex_valid_o, ex_rs_o); end
    n_cmp++; if (obs !== m_vec) begin n_fail++; $display("FAIL lu_bundle obs=%h req=%h", obs, m_vec); end
  endtask

  task automatic test_no_hazard();
    drive(LW8, C_LW, 3'b000);
    tick();
    drive(32'h212B0001, C_ALUI, 3'b000);  // addi $11,$9,1
    @(negedge clk_i);
    n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL nh_rt_unused obs=%b req=0", stall_o); end
    tick();
    n_cmp++; if ({ex_valid_o, ex_rt_o} !== {1'b1, 5'd11}) begin n_fail++; $display("FAIL nh_load1 valid=%b rt=%0d req 1/11", ex_valid_o, ex_rt_o); end
    drive(32'h8D200000, C_LW, 3'b000);    // lw $0, 0($9)
    tick();
    drive(32'h00005020, C_RT, 3'b010);    // add $10,$0,$0
    @(negedge clk_i);
    n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL nh_zero_reg obs=%b req=0", stall_o); end
    tick();
    n_cmp++; if (obs !== m_vec || ex_valid_o !== 1'b1) begin n_fail++; $display("FAIL nh_load2 obs=%h req=%h", obs, m_vec); end
  endtask

  task automatic test_flush();
    int cnt0;
    drive(LW8, C_LW, 3'b000);
    tick();
    cnt0 = m_cnt;
    drive(ADD8, C_RT, 3'b010);
    flush_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL fl_stall obs=%b req=0", stall_o); end
    tick();
    n_cmp++; if (obs !== 160'd0) begin n_fail++; $display("FAIL fl_bubble obs=%h req=0", obs); end
    n_cmp++; if (bubble_cnt_o !== 16'(cnt0)) begin n_fail++; $display("FAIL fl_cnt obs=%0d req=%0d", bubble_cnt_o, cnt0); end
    flush_i = 1'b0;
  endtask

  task automatic test_reset_mid_stall();
    drive(LW8, C_LW, 3'b000);
    tick();
    drive(ADD8, C_RT, 3'b010);
    rst_i = 1'b0;
    tick();
    n_cmp++; if (obs !== 160'd0 || bubble_cnt_o !== 16'd0) begin n_fail++; $display("FAIL rms_clear obs=%h cnt=%0d req 0/0", obs, bubble_cnt_o); end
    rst_i = 1'b1;
    @(negedge clk_i);
    n_cmp++; if (stall_o !== 1'b0) begin n_fail++; $display("FAIL rms_stall obs=%b req=0", stall_o); end
    tick();
  endtask

  task automatic test_saturate();
    int req [5];
    req = '{1, 2, 3, 3, 3};
    rst_i = 1'b0;
    tick();
    rst_i = 1'b1;
    for (int k = 0; k < 5; k++) begin
      drive(LW8, C_LW, 3'b000);
      tick();
      drive(ADD8, C_RT, 3'b010);
      tick();
      n_cmp++; if (cnt2 !== 2'(req[k])) begin n_fail++; $display("FAIL sat_cnt%0d obs=%0d req=%0d", k, cnt2, req[k]); end
    end
  endtask

  task automatic test_random();
    logic [5:0] ops [8];
    ops = '{6'h00, 6'h04, 6'h05, 6'h01, 6'h07, 6'h2B, 6'h23, 6'h08};
    for (int i = 0; i < 600; i++) begin
      // Upstream holds the ID instruction while stalled; otherwise new traffic.
      if (!model_stall()) begin
        drive({ops[$urandom_range(7)], 5'($urandom_range(3)), 5'($urandom_range(3)), 16'($urandom)},
              7'($urandom), 3'($urandom));
        ctrl[2]    = ($urandom_range(99) < 45);
        id_valid_i = ($urandom_range(99) < 85);
      end
      flush_i = ($urandom_range(99) < 10);
      rst_i   = ($urandom_range(99) >= 2);
      @(negedge clk_i);
      n_cmp++; if (stall_o !== model_stall()) begin n_fail++; $display("FAIL rnd_stall i=%0d obs=%b req=%b", i, stall_o, model_stall()); end
      tick();
      n_cmp++; if (obs !== m_vec) begin n_fail++; $display("FAIL rnd_bundle i=%0d obs=%h req=%h", i, obs, m_vec); end
      n_cmp++; if (obs2 !== m_vec) begin n_fail++; $display("FAIL rnd_bundle2 i=%0d obs=%h req=%h", i, obs2, m_vec); end
      n_cmp++; if (bubble_cnt_o !== 16'(m_cnt)) begin n_fail++; $display("FAIL rnd_cnt i=%0d obs=%0d req=%0d", i, bubble_cnt_o, m_cnt); end
      n_cmp++; if (cnt2 !== 2'(m_cnt2)) begin n_fail++; $display("FAIL rnd_cnt2 i=%0d obs=%0d req=%0d", i, cnt2, m_cnt2); end
    end
    rst_i = 1'b1;
  endtask

  initial begin
    model_clear();
    m_cnt = 0; m_cnt2 = 0;
    test_reset();
    test_load();
    test_load_use();
    test_no_hazard();
    test_flush();
    test_reset_mid_stall();
    test_saturate();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register with built-in load-use hazard detection for the 5-stage MIPS pipeline.
- Sits directly downstream of the instruction decoder.
- Captures the decoder's control bundle, register-file read data, sign-extended immediate and register specifiers on each clock, for the EX stage.
- Inserts a bubble and raises a stall to PC/IF-ID on a load-use hazard.
- Zeroes its contents on a branch flush.
- Keeps a saturating bubble counter for performance debug.

Parameters:
- DW, 32, datapath width (PC, register data, immediate).
- CNT_W, 16, width of the bubble counter.

Ports:
- clk_i  in  1  clock; all state updates on rising edge.
- rst_i  in  1  reset; synchronous, active-low.
- id_valid_i  in  1  ID holds a real instruction.
- id_instr_i  in  32  instruction in ID: op [31:26], rs [25:21], rt [20:16], rd [15:11], imm [15:0].
- id_pc_plus4_i  in  DW  PC+4 of the ID instruction.
- id_rs_data_i  in  DW  register-file read data for rs.
- id_rt_data_i  in  DW  register-file read data for rt.
- id_RegWrite_i, id_ALUSrc_i, id_RegDst_i, id_Branch_i, id_MemRead_i, id_MemWrite_i, id_MemtoReg_i  in  1 each  decoder controls.
- id_ALU_op_i  in  3  decoder ALU op.
- flush_i  in  1  branch taken, resolved downstream; kill ID.
- stall_o  out  1  hold PC and IF/ID this cycle (combinational).
- ex_valid_o  out  1  EX holds a real instruction.
- ex_op_o  out  6  opcode, passed through for branch-type selection.
- ex_pc_plus4_o, ex_rs_data_o, ex_rt_data_o, ex_imm_o  out  DW each  registered datapath fields.
- ex_rs_o, ex_rt_o, ex_rd_o  out  5 each  register specifiers.
- ex_RegWrite_o, ex_ALUSrc_o, ex_RegDst_o, ex_Branch_o, ex_MemRead_o, ex_MemWrite_o, ex_MemtoReg_o  out  1 each  registered controls.
- ex_ALU_op_o  out  3  registered ALU op.
- bubble_cnt_o  out  CNT_W  count of load-use bubbles inserted, saturating.

Behaviour:
- Reset (rst_i=0 at clock edge): every ex_* output and bubble_cnt_o go to 0. stall_o is still combinational but sees ex_MemRead_o=0, so it is 0 from the first post-reset cycle.
- uses_rt: op is one of 000000 (R-type), 000100 (beq), 000101 (bne), 000001 (bge), 000111 (bgt), 101011 (sw).
- load_use is asserted when all of the following hold:
  - id_valid_i and ex_valid_o and ex_MemRead_o are 1;
  - ex_rt_o != 0;
  - ex_rt_o == id rs, or (uses_rt and ex_rt_o == id rt).
- stall_o = load_use AND NOT flush_i.
- Update priority at each edge, highest first:
  1. reset;
  2. flush_i=1: bubble;
  3. load_use: bubble, and bubble_cnt_o increments;
  4. id_valid_i=0: bubble;
  5. otherwise, normal load.
- Bubble: every ex_* output becomes 0, including data fields and ex_valid_o.
- Normal load: ex_valid_o=1.
  - Controls and ALU op are copied from the decoder inputs.
  - ex_op_o, ex_rs_o, ex_rt_o, ex_rd_o are taken from the instruction fields.
  - ex_imm_o is imm[15:0] sign-extended to DW.
  - pc_plus4, rs_data and rt_data are copied.
- Latency: exactly one cycle from ID inputs to ex_* outputs. No internal holding; during a stall the upstream stages keep the ID inputs stable.
- A stall lasts exactly one cycle. The bubble clears ex_MemRead_o, so load_use deasserts the next cycle and the held instruction loads normally.
- Flush has priority over hazard: when load_use and flush_i coincide, stall_o=0, a bubble is inserted and bubble_cnt_o is unchanged.
- bubble_cnt_o saturates at 2^CNT_W-1 (no wrap). It clears only on reset.
- Reset mid-stall: outputs clear; the stall drops the next cycle.

Test Plan:
1. Hold rst_i=0 for 2 cycles with arbitrary ID inputs -> all ex_* = 0, bubble_cnt_o=0, stall_o=0.
2. ID = 0x21280005 (addi $8,$9,5) with RegWrite=1, ALUSrc=1, ALU_op=000 -> after one edge: ex_valid_o=1, ex_rs_o=9, ex_rt_o=8, ex_imm_o=0x00000005, ex_RegWrite_o=1, ex_ALUSrc_o=1. Repeat with imm 0x8000 -> ex_imm_o=0xFFFF8000.
3. EX holds lw $8 (MemRead=1, rt=8); ID holds add $10,$8,$9:
   - same cycle: stall_o=1;
   - next edge: all ex_* = 0, bubble_cnt_o=1;
   - following cycle: stall_o=0;
   - next edge: the add is loaded with ex_rs_o=8.
4. No-hazard cases, each giving stall_o=0 and a normal load of the ID instruction:
   - EX lw $8, ID addi $11,$9,1 (rt not used, rs=9);
   - EX lw $0, ID add using $0.
5. Load-use condition as in scenario 3 with flush_i=1 in the same cycle -> stall_o=0; next edge: bubble, bubble_cnt_o unchanged.
6. CNT_W=2, force 5 separate load-use bubbles -> bubble_cnt_o reads 1, 2, 3, 3, 3.
